uart_rx: RTL and testbench

UART receiver for the riscv_unit SoC. It deserialises the rx_i line into bytes. Frame format is the one the SoC transmitter drives: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (parity = XOR of data), 1 stop bit (1). Received bytes go to the peripheral bus side through a valid/ready holding stage, with parity, frame and overrun status.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (receiver FSM states, frame format,
// baud helpers) used by the RX/TX blocks and their benches.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } uart_parity_t;

  localparam int           UART_DATA_BITS     = 8;
  localparam uart_parity_t UART_PARITY        = PARITY_EVEN;
  localparam int           UART_RX_FIFO_DEPTH = 4;

  // Clocks per line bit for a given system clock and baud rate.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Parity bit the transmitter appends to a data byte.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                      input uart_parity_t ptype);
    return (^data) ^ (ptype == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO for received bytes. A push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_DEPTH);
  assign empty     = (count_r == '0);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 1 start, 8 data (LSB first), even parity, 1 stop.
// Bytes leave through a valid/ready stage with parity/frame/overrun pulses.
// Build option UART_RX_FIFO_EN: 4-entry output FIFO instead of a single
// holding register; ports and handshake are the same in both builds.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUDRATE = 115200
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      busy_o,
  output logic                      parity_err_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       LAST_BIT      = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta_r;
  logic                      rx_sync_r;
  logic                      rx_prev_r;
  uart_rx_state_t            state_r;
  logic [CNT_W-1:0]          baud_cnt_r;
  logic [2:0]                bit_idx_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic                      parity_ok_r;
  logic                      busy_r;
  logic                      frame_err_r;
  logic                      parity_err_r;
  logic                      good_r;
  logic                      overrun_r;
  logic                      pop_s;

  // Two-flop synchronizer for the async line plus one flop for edge detect.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Frame FSM: start qualification, mid-bit sampling, stop-bit verdict.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r      <= IDLE;
      baud_cnt_r   <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= '0;
      parity_ok_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      good_r       <= 1'b0;
    end else begin
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      good_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          // Only a high-to-low transition starts a frame; a held-low line does not.
          if (!rx_sync_r && rx_prev_r) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt_r == CNT_HALF_LAST) begin
            baud_cnt_r <= '0;
            if (rx_sync_r) begin
              // Line back high at mid start bit: treat as a glitch.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (baud_cnt_r == CNT_BIT_LAST) begin
            baud_cnt_r         <= '0;
            shift_r[bit_idx_r] <= rx_sync_r;
            if (bit_idx_r == LAST_BIT) begin
              state_r <= PARITY;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        PARITY: begin
          if (baud_cnt_r == CNT_BIT_LAST) begin
            baud_cnt_r  <= '0;
            parity_ok_r <= (rx_sync_r == parity_bit(shift_r, UART_PARITY));
            state_r     <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (baud_cnt_r == CNT_BIT_LAST) begin
            baud_cnt_r <= '0;
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            // Frame error outranks parity error; only clean frames are pushed.
            if (!rx_sync_r) begin
              frame_err_r <= 1'b1;
            end else if (!parity_ok_r) begin
              parity_err_r <= 1'b1;
            end else begin
              good_r <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= '0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [UART_DATA_BITS-1:0] fifo_rdata_s;

  assign pop_s = ~fifo_empty_s & rx_ready_i;

  uart_rx_fifo #(
    .DEPTH (UART_RX_FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (resetn_i),
    .push  (good_r),
    .pop   (pop_s),
    .wdata (shift_r),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Flag a good byte that found every FIFO slot occupied and nothing leaving.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= good_r & fifo_full_s & ~pop_s;
    end
  end

  assign rx_valid_o = ~fifo_empty_s;
  assign rx_data_o  = fifo_rdata_s;
`else
  logic [UART_DATA_BITS-1:0] hold_data_r;
  logic                      hold_valid_r;

  assign pop_s = hold_valid_r & rx_ready_i;

  // Single holding register; a same-cycle pop frees the slot for the new byte.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      hold_data_r  <= '0;
      hold_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (good_r) begin
        if (!hold_valid_r || pop_s) begin
          hold_data_r  <= shift_r;
          hold_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (pop_s) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
    end
  end

  assign rx_valid_o = hold_valid_r;
  assign rx_data_o  = hold_data_r;
`endif

  assign busy_o       = busy_r;
  assign parity_err_o = parity_err_r;
  assign frame_err_o  = frame_err_r;
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized frames against a queue-based model of
// the receiver's delivery rules. Uses a fast baud setting (32 clocks/bit).
module tb_uart_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int LAT_MIN  = 10 * CPB + HALF;
  localparam int LAT_MAX  = 10 * CPB + HALF + 6;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD)) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .rx_i         (rx),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (ready),
    .busy_o       (busy),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts pulse cycles, captures popped bytes, watches data stability.
  int          n_frame = 0, n_parity = 0, n_overrun = 0, n_got = 0, n_unstable = 0;
  logic [7:0]  got_mem [256];
  int unsigned t_valid_rise = 0;
  logic        valid_d = 1'b0, pop_d = 1'b0;
  logic [7:0]  data_d = 8'h00;
  always @(negedge clk) begin
    if (!resetn) begin
      valid_d <= 1'b0;
      pop_d   <= 1'b0;
    end else begin
      if (frame_err)  n_frame   <= n_frame + 1;
      if (parity_err) n_parity  <= n_parity + 1;
      if (overrun)    n_overrun <= n_overrun + 1;
      if (rx_valid && ready) begin
        got_mem[n_got[7:0]] <= rx_data;
        n_got <= n_got + 1;
      end
      if (rx_valid && !valid_d) t_valid_rise <= cyc;
      if (valid_d && !pop_d && rx_valid && (rx_data !== data_d)) n_unstable <= n_unstable + 1;
      valid_d <= rx_valid;
      pop_d   <= rx_valid & ready;
      data_d  <= rx_data;
    end
  end

  // Reference model state.
  int          checks = 0, errors = 0;
  int          exp_frame = 0, exp_parity = 0, exp_overrun = 0;
  logic [7:0]  exp_bytes [$];
  logic [7:0]  mq [$];
  int          got_rd = 0;
  int unsigned t_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame outcome from the line rules: stop, then even parity, then storage room.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) exp_frame++;
    else if (par !== ^d) exp_parity++;
    else if (ready) exp_bytes.push_back(d);
    else if (mq.size() < DEPTH) mq.push_back(d);
    else exp_overrun++;
  endtask

  task automatic model_drain();
    while (mq.size() > 0) exp_bytes.push_back(mq.pop_front());
  endtask

  task automatic drive_bits(input logic [10:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx = v[i];
      tick(CPB);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    t_start = cyc;
    drive_bits({stop, par, d, 1'b0}, 11);
    model_frame(d, par, stop);
  endtask

  task automatic send_good(input logic [7:0] d);
    send(d, ^d, 1'b1);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, 32'(n_got - got_rd), 32'(exp_bytes.size()));
    while (exp_bytes.size() > 0 && got_rd < n_got) begin
      check({tag, "_byte"}, {24'd0, got_mem[got_rd[7:0]]}, {24'd0, exp_bytes.pop_front()});
      got_rd++;
    end
    exp_bytes.delete();
    got_rd = n_got;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"},  32'(n_frame),   32'(exp_frame));
    check({tag, "_parity_err"}, 32'(n_parity),  32'(exp_parity));
    check({tag, "_overrun"},    32'(n_overrun), 32'(exp_overrun));
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected CHECKS %0d ERRORS %0d done", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [7:0] d;
    int kind;

    // Reset state.
    resetn = 1'b0; rx = 1'b1; ready = 1'b1;
    tick(3);
    check("reset_outputs", {19'd0, rx_valid, busy, parity_err, frame_err, overrun, rx_data}, 32'd0);
    resetn = 1'b1;
    tick(2 * CPB);
    check("idle_outputs", {19'd0, rx_valid, busy, parity_err, frame_err, overrun, rx_data}, 32'd0);

    // Clean 0x55 with consumer ready: one byte, latency ~10.5 bits.
    send_good(8'h55);
    tick(4);
    lat = int'(t_valid_rise - t_start);
    check("latency_55", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
    compare_bytes("b55");
    check_counts("c55");

    // 0xA7 with wrong parity bit.
    send(8'hA7, 1'b0, 1'b1);
    tick(4);
    compare_bytes("bA7");
    check_counts("cA7");

    // 0x3C with stop bit 0, line low 3 bit times, then 0x81.
    send(8'h3C, ^8'h3C, 1'b0);
    tick(2 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    send_good(8'h81);
    tick(4);
    compare_bytes("b3C81");
    check_counts("c3C81");

    // Short low glitch: busy rises then falls, nothing reported.
    rx = 1'b0;
    tick(4);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    tick(HALF + 4);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    tick(CPB);
    compare_bytes("bglitch");
    check_counts("cglitch");

    // Consumer stalled, five back-to-back bytes.
    ready = 1'b0;
    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    send_good(8'h44);
    send_good(8'h55);
    tick(4);
    check_counts("covr");
    check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_head_byte", {24'd0, rx_data}, {24'd0, mq[0]});
    ready = 1'b1;
    model_drain();
    tick(DEPTH + 4);
    compare_bytes("bovr");

    // Reset in the middle of 0x99's data bits, then 0x42.
    drive_bits({1'b1, ^8'h99, 8'h99, 1'b0}, 5);
    resetn = 1'b0;
    tick(2);
    check("midreset_outputs", {19'd0, rx_valid, busy, parity_err, frame_err, overrun, rx_data}, 32'd0);
    rx = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(2 * CPB);
    send_good(8'h42);
    tick(4);
    compare_bytes("breset");
    check_counts("creset");

    // Randomized frames: good, bad parity or bad stop bit.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        send(d, ~(^d), 1'b1);
      end else if (kind == 1) begin
        send(d, ^d, 1'b0);
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
      end else begin
        send_good(d);
      end
      tick(int'($urandom_range(0, CPB)));
    end
    tick(4);
    compare_bytes("brand");
    check_counts("crand");
    check("data_stable", 32'(n_unstable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
